// File: rtl/cci_mpf_if_pkg.sv
// Shared CCI-MPF request/response structs and default tx-buffer sizing.
package cci_mpf_if_pkg;

   localparam int CCI_MPF_TX_BUF_N_ENTRIES = 8;
   localparam int CCI_MPF_TX_BUF_THRESHOLD = 4;

   typedef struct packed {
      logic        valid;
      logic [15:0] mdata;
      logic [41:0] addr;
   } t_if_cci_mpf_c0_Tx;

   typedef struct packed {
      logic        valid;
      logic [15:0] mdata;
      logic [41:0] addr;
      logic [63:0] data;
   } t_if_cci_mpf_c1_Tx;

   typedef struct packed {
      logic        valid;
      logic [8:0]  tid;
      logic [63:0] data;
   } t_if_cci_mpf_c2_Tx;

   typedef struct packed {
      logic        valid;
      logic [15:0] mdata;
      logic [63:0] data;
   } t_if_cci_mpf_c0_Rx;

   typedef struct packed {
      logic        valid;
      logic [15:0] mdata;
   } t_if_cci_mpf_c1_Rx;

endpackage

// File: rtl/cci_mpf_if.sv
// CCI-MPF link bundle; to_fiu drives requests toward the platform, to_afu faces user logic.
interface cci_mpf_if;
   import cci_mpf_if_pkg::*;

   t_if_cci_mpf_c0_Tx c0Tx;
   t_if_cci_mpf_c1_Tx c1Tx;
   t_if_cci_mpf_c2_Tx c2Tx;
   logic              c0TxAlmFull;
   logic              c1TxAlmFull;
   t_if_cci_mpf_c0_Rx c0Rx;
   t_if_cci_mpf_c1_Rx c1Rx;
   logic              reset;

   modport to_fiu (
      output c0Tx, c1Tx, c2Tx,
      input  c0TxAlmFull, c1TxAlmFull, c0Rx, c1Rx, reset
   );

   modport to_afu (
      input  c0Tx, c1Tx, c2Tx,
      output c0TxAlmFull, c1TxAlmFull, c0Rx, c1Rx, reset
   );

endinterface

// File: rtl/cci_mpf_prim_fifo_lutram.sv
// Distributed-RAM FIFO storage with wrapping pointers; head is read combinationally.
// Caller owns occupancy and must never enqueue into a full FIFO without a same-cycle dequeue.
module cci_mpf_prim_fifo_lutram #(
   parameter int N_DATA_BITS = 32,
   parameter int N_ENTRIES   = 8
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enq_en,
   input  logic [N_DATA_BITS-1:0] enq_data,
   input  logic                   deq_en,
   output logic [N_DATA_BITS-1:0] first
);
   localparam int AW = $clog2(N_ENTRIES);

   logic [N_DATA_BITS-1:0] mem [N_ENTRIES];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (enq_en) wr_ptr <= wr_ptr + 1'b1;
         if (deq_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (enq_en) mem[wr_ptr] <= enq_data;
   end

   assign first = mem[rd_ptr];

endmodule

// File: rtl/cci_mpf_shim_tx_buffer.sv
// Buffers c0/c1 requests ahead of fiu almost-full (2-cycle min latency); c2Tx, Rx and reset pass through one register.
// afu almost-full is registered and asserts once free slots <= THRESHOLD; requests into a full FIFO are dropped.
module cci_mpf_shim_tx_buffer
   import cci_mpf_if_pkg::*;
#(
   parameter int N_ENTRIES         = CCI_MPF_TX_BUF_N_ENTRIES,
   parameter int THRESHOLD         = CCI_MPF_TX_BUF_THRESHOLD,
   parameter bit FATAL_ON_OVERFLOW = 1'b1
)(
   input  logic      clk,
   input  logic      reset,
   cci_mpf_if.to_fiu fiu,
   cci_mpf_if.to_afu afu
);
   localparam int CW = $clog2(N_ENTRIES) + 1;
   localparam int W0 = $bits(t_if_cci_mpf_c0_Tx);
   localparam int W1 = $bits(t_if_cci_mpf_c1_Tx);

   logic [CW-1:0]     c0_cnt, c0_cnt_nxt;
   logic [CW-1:0]     c1_cnt, c1_cnt_nxt;
   logic              c0_full, c0_enq, c0_deq, c0_drop;
   logic              c1_full, c1_enq, c1_deq, c1_drop;
   t_if_cci_mpf_c0_Tx c0_first;
   t_if_cci_mpf_c1_Tx c1_first;
   logic              overflow;

   // A full FIFO still accepts a request when its head leaves in the same cycle.
   always_comb begin
      c0_full    = (c0_cnt == CW'(N_ENTRIES));
      c0_deq     = (c0_cnt != '0) && !fiu.c0TxAlmFull;
      c0_enq     = afu.c0Tx.valid && (!c0_full || c0_deq);
      c0_drop    = afu.c0Tx.valid && !c0_enq;
      c0_cnt_nxt = c0_cnt + CW'(c0_enq) - CW'(c0_deq);

      c1_full    = (c1_cnt == CW'(N_ENTRIES));
      c1_deq     = (c1_cnt != '0) && !fiu.c1TxAlmFull;
      c1_enq     = afu.c1Tx.valid && (!c1_full || c1_deq);
      c1_drop    = afu.c1Tx.valid && !c1_enq;
      c1_cnt_nxt = c1_cnt + CW'(c1_enq) - CW'(c1_deq);
   end

   cci_mpf_prim_fifo_lutram #(
      .N_DATA_BITS (W0),
      .N_ENTRIES   (N_ENTRIES)
   ) c0_fifo (
      .clk      (clk),
      .reset    (reset),
      .enq_en   (c0_enq),
      .enq_data (afu.c0Tx),
      .deq_en   (c0_deq),
      .first    (c0_first)
   );

   cci_mpf_prim_fifo_lutram #(
      .N_DATA_BITS (W1),
      .N_ENTRIES   (N_ENTRIES)
   ) c1_fifo (
      .clk      (clk),
      .reset    (reset),
      .enq_en   (c1_enq),
      .enq_data (afu.c1Tx),
      .deq_en   (c1_deq),
      .first    (c1_first)
   );

   always_ff @(posedge clk) begin
      afu.reset <= fiu.reset;
      if (reset) begin
         c0_cnt          <= '0;
         c1_cnt          <= '0;
         overflow        <= 1'b0;
         fiu.c0Tx        <= '0;
         fiu.c1Tx        <= '0;
         fiu.c2Tx        <= '0;
         afu.c0Rx        <= '0;
         afu.c1Rx        <= '0;
         afu.c0TxAlmFull <= 1'b1;
         afu.c1TxAlmFull <= 1'b1;
      end else begin
         c0_cnt   <= c0_cnt_nxt;
         c1_cnt   <= c1_cnt_nxt;
         fiu.c0Tx <= '0;
         fiu.c1Tx <= '0;
         if (c0_deq) fiu.c0Tx <= c0_first;
         if (c1_deq) fiu.c1Tx <= c1_first;
         fiu.c2Tx <= afu.c2Tx;
         afu.c0Rx <= fiu.c0Rx;
         afu.c1Rx <= fiu.c1Rx;
         afu.c0TxAlmFull <= (CW'(N_ENTRIES) - c0_cnt_nxt) <= CW'(THRESHOLD);
         afu.c1TxAlmFull <= (CW'(N_ENTRIES) - c1_cnt_nxt) <= CW'(THRESHOLD);
         if (c0_drop || c1_drop) begin
            overflow <= 1'b1;
            assert (!FATAL_ON_OVERFLOW)
               else $fatal(1, "cci_mpf_shim_tx_buffer: request dropped at full FIFO");
         end
      end
   end

endmodule
